// File: rtl/matmul_seq.sv
// Sequential matrix multiplier: one MAC unit time-shared over every Result element.
// Operands are captured on start; the full result is published with a one-cycle done pulse.
module matmul_seq #(
  parameter int M      = 5,
  parameter int K      = 2,
  parameter int N      = 3,
  parameter int DW     = 8,
  parameter int RW     = 2*DW + $clog2(K),
  parameter int SIGNED = 0
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                start,
  input  logic [M*K*DW-1:0]   MatrixA,
  input  logic [K*N*DW-1:0]   MatrixB,
  output logic [M*N*RW-1:0]   MatrixResult,
  output logic                busy,
  output logic                done
);

  localparam int AW = 2*DW + $clog2(K);
  localparam int IW = (M > 1) ? $clog2(M) : 1;
  localparam int JW = (N > 1) ? $clog2(N) : 1;
  localparam int KW = (K > 1) ? $clog2(K) : 1;

  localparam logic [0:0] IDLE = 1'b0;
  localparam logic [0:0] CALC = 1'b1;

  logic [0:0]          state;
  logic [M*K*DW-1:0]   bufA;
  logic [K*N*DW-1:0]   bufB;
  logic [M*N*RW-1:0]   resBuf;
  logic [M*N*RW-1:0]   nextRes;
  logic [AW-1:0]       acc;
  logic [AW-1:0]       aExt;
  logic [AW-1:0]       bExt;
  logic [AW-1:0]       prod;
  logic [AW-1:0]       sum;
  logic [DW-1:0]       aElem;
  logic [DW-1:0]       bElem;
  logic [RW-1:0]       resElem;
  logic [IW-1:0]       i;
  logic [JW-1:0]       j;
  logic [KW-1:0]       k;
  logic                lastI;
  logic                lastJ;
  logic                lastK;
  int                  aIdx;
  int                  bIdx;
  int                  resIdx;

  assign busy  = (state == CALC);
  assign lastI = (i == IW'(M-1));
  assign lastJ = (j == JW'(N-1));
  assign lastK = (k == KW'(K-1));

  // The accumulator is wide enough for the exact sum, so modulo-AW arithmetic on
  // sign/zero-extended operands yields the exact result in both operand modes.
  always_comb begin
    aIdx    = (M*K-1) - (int'(i)*K + int'(k));
    bIdx    = (K*N-1) - (int'(k)*N + int'(j));
    resIdx  = (M*N-1) - (int'(i)*N + int'(j));
    aElem   = bufA[aIdx*DW +: DW];
    bElem   = bufB[bIdx*DW +: DW];
    aExt    = {{(AW-DW){(SIGNED != 0) & aElem[DW-1]}}, aElem};
    bExt    = {{(AW-DW){(SIGNED != 0) & bElem[DW-1]}}, bElem};
    prod    = aExt * bExt;
    sum     = acc + prod;
    nextRes = resBuf;
    if (lastK) begin
      nextRes[resIdx*RW +: RW] = resElem;
    end
  end

  generate
    if (RW <= AW) begin : gTrunc
      assign resElem = sum[RW-1:0];
    end else begin : gExtend
      assign resElem = {{(RW-AW){(SIGNED != 0) & sum[AW-1]}}, sum};
    end
  endgenerate

  // The final element is merged via nextRes so MatrixResult gets the whole matrix
  // on the completion edge itself.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= IDLE;
      bufA         <= '0;
      bufB         <= '0;
      resBuf       <= '0;
      MatrixResult <= '0;
      acc          <= '0;
      i            <= '0;
      j            <= '0;
      k            <= '0;
      done         <= 1'b0;
    end else begin
      done <= 1'b0;
      if (state == IDLE) begin
        if (start) begin
          bufA  <= MatrixA;
          bufB  <= MatrixB;
          acc   <= '0;
          i     <= '0;
          j     <= '0;
          k     <= '0;
          state <= CALC;
        end
      end else begin
        if (lastK) begin
          resBuf <= nextRes;
          acc    <= '0;
          k      <= '0;
          if (lastJ) begin
            j <= '0;
            if (lastI) begin
              i            <= '0;
              MatrixResult <= nextRes;
              done         <= 1'b1;
              state        <= IDLE;
            end else begin
              i <= i + 1'b1;
            end
          end else begin
            j <= j + 1'b1;
          end
        end else begin
          acc <= sum;
          k   <= k + 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_matmul_seq.sv
// Bench for matmul_seq: an unsigned and a signed instance checked against a plain
// arithmetic matrix-product model, plus handshake, reset and back-to-back scenarios.
module tb_matmul_seq;

  localparam int M    = 5;
  localparam int K    = 2;
  localparam int N    = 3;
  localparam int DW   = 8;
  localparam int RW   = 17;
  localparam int LAT  = M*N*K;
  localparam int AWID = M*K*DW;
  localparam int BWID = K*N*DW;
  localparam int RWID = M*N*RW;

  logic            clk    = 1'b0;
  logic            rst_n  = 1'b0;
  logic            startU = 1'b0;
  logic            startS = 1'b0;
  logic [AWID-1:0] aU     = '0;
  logic [AWID-1:0] aS     = '0;
  logic [BWID-1:0] bU     = '0;
  logic [BWID-1:0] bS     = '0;
  logic [RWID-1:0] resU;
  logic [RWID-1:0] resS;
  logic            busyU;
  logic            busyS;
  logic            doneU;
  logic            doneS;

  int compared   = 0;
  int mismatched = 0;

  logic [RWID-1:0] lastU = '0;
  logic [RWID-1:0] lastS = '0;

  always #5 clk = ~clk;

  matmul_seq #(.M(M), .K(K), .N(N), .DW(DW), .RW(RW), .SIGNED(0)) dutU (
    .clk(clk), .rst_n(rst_n), .start(startU), .MatrixA(aU), .MatrixB(bU),
    .MatrixResult(resU), .busy(busyU), .done(doneU)
  );

  matmul_seq #(.M(M), .K(K), .N(N), .DW(DW), .RW(RW), .SIGNED(1)) dutS (
    .clk(clk), .rst_n(rst_n), .start(startS), .MatrixA(aS), .MatrixB(bS),
    .MatrixResult(resS), .busy(busyS), .done(doneS)
  );

  // Textbook triple loop on integer values, truncated to RW bits.
  function automatic logic [RWID-1:0] refMul(input logic [AWID-1:0] a,
                                             input logic [BWID-1:0] b,
                                             input bit sgn);
    logic [RWID-1:0]    r;
    logic signed [63:0] sum;
    logic signed [63:0] av;
    logic signed [63:0] bv;
    logic [DW-1:0]      ea;
    logic [DW-1:0]      eb;
    r = '0;
    for (int row = 0; row < M; row++) begin
      for (int col = 0; col < N; col++) begin
        sum = 0;
        for (int kk = 0; kk < K; kk++) begin
          ea = a[((M*K-1)-(row*K+kk))*DW +: DW];
          eb = b[((K*N-1)-(kk*N+col))*DW +: DW];
          av = 64'(ea);
          bv = 64'(eb);
          if (sgn && ea[DW-1]) av = av - (64'sd1 <<< DW);
          if (sgn && eb[DW-1]) bv = bv - (64'sd1 <<< DW);
          sum = sum + av*bv;
        end
        r[((M*N-1)-(row*N+col))*RW +: RW] = sum[RW-1:0];
      end
    end
    return r;
  endfunction

  task automatic checkOutput(input string tag, input logic [RWID-1:0] obs,
                             input logic [RWID-1:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic applyStimulus(input bit sel, input logic [AWID-1:0] a,
                               input logic [BWID-1:0] b);
    if (sel) begin
      aS = a; bS = b; startS = 1'b1;
    end else begin
      aU = a; bU = b; startU = 1'b1;
    end
    @(posedge clk);
    #1;
    startS = 1'b0;
    startU = 1'b0;
  endtask

  // Full operation: exact latency, busy/done timing, stable result while computing.
  task automatic runOp(input bit sel, input logic [AWID-1:0] a,
                       input logic [BWID-1:0] b, input string tag);
    logic [RWID-1:0] exp;
    logic [RWID-1:0] prev;
    exp  = refMul(a, b, sel);
    prev = sel ? lastS : lastU;
    applyStimulus(sel, a, b);
    checkOutput({tag, " busy@start"}, sel ? busyS : busyU, 1);
    for (int n = 1; n <= LAT; n++) begin
      @(posedge clk);
      #1;
      checkOutput({tag, " busy"}, sel ? busyS : busyU, (n < LAT));
      checkOutput({tag, " done"}, sel ? doneS : doneU, (n == LAT));
      checkOutput({tag, " result"}, sel ? resS : resU, (n < LAT) ? prev : exp);
    end
    @(posedge clk);
    #1;
    checkOutput({tag, " done cleared"}, sel ? doneS : doneU, 0);
    if (sel) lastS = exp;
    else lastU = exp;
  endtask

  initial begin
    logic [AWID-1:0] t1A;
    logic [BWID-1:0] t1B;
    logic [AWID-1:0] t2A;
    logic [BWID-1:0] t2B;
    logic [AWID-1:0] xA;
    logic [BWID-1:0] xB;
    logic [RWID-1:0] exp1;
    logic [RWID-1:0] exp2;

    for (int r = 0; r < M; r++)
      for (int c = 0; c < K; c++)
        t1A[((M*K-1)-(r*K+c))*DW +: DW] = DW'(c + 1);
    for (int r = 0; r < K; r++)
      for (int c = 0; c < N; c++)
        t1B[((K*N-1)-(r*N+c))*DW +: DW] = DW'(r*N + c + 1);
    t2A = '1;
    t2B = '1;

    repeat (2) @(posedge clk);
    #1;
    checkOutput("reset busyU", busyU, 0);
    checkOutput("reset doneU", doneU, 0);
    checkOutput("reset resU", resU, 0);
    checkOutput("reset resS", resS, 0);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    runOp(0, t1A, t1B, "t1");
    checkOutput("t1 r00", resU[RWID-1 -: RW], 17'h00009);
    checkOutput("t1 r21", resU[7*RW +: RW], 17'h0000C);
    checkOutput("t1 r42", resU[RW-1:0], 17'h0000F);

    runOp(0, t2A, t2B, "t2");
    checkOutput("t2 r42", resU[RW-1:0], 17'h1FC02);

    xA = '0; xB = '0;
    for (int e = 0; e < M*K; e++) xA[e*DW +: DW] = 8'h80;
    for (int e = 0; e < K*N; e++) xB[e*DW +: DW] = 8'h80;
    runOp(1, xA, xB, "t3a");
    checkOutput("t3a r00", resS[RWID-1 -: RW], 17'h08000);

    for (int r = 0; r < M; r++) begin
      xA[((M*K-1)-(r*K))*DW +: DW]   = 8'hFF;
      xA[((M*K-1)-(r*K+1))*DW +: DW] = 8'h00;
    end
    for (int c = 0; c < N; c++) begin
      xB[((K*N-1)-c)*DW +: DW]     = 8'h7F;
      xB[((K*N-1)-(N+c))*DW +: DW] = DW'($urandom);
    end
    runOp(1, xA, xB, "t3b");
    checkOutput("t3b r00", resS[RWID-1 -: RW], 17'h1FF81);
    checkOutput("t3b r42", resS[RW-1:0], 17'h1FF81);

    for (int it = 0; it < 4; it++) begin
      for (int e = 0; e < M*K; e++) xA[e*DW +: DW] = DW'($urandom);
      for (int e = 0; e < K*N; e++) xB[e*DW +: DW] = DW'($urandom);
      runOp(0, xA, xB, "randU");
      runOp(1, xA, xB, "randS");
    end

    // A second start while busy must neither restart nor queue an operation.
    exp1 = refMul(t1A, t1B, 0);
    applyStimulus(0, t1A, t1B);
    for (int n = 1; n <= LAT + 15; n++) begin
      @(posedge clk);
      #1;
      checkOutput("t4 done", doneU, (n == LAT));
      checkOutput("t4 busy", busyU, (n < LAT));
      checkOutput("t4 result", resU, (n < LAT) ? lastU : exp1);
      if (n == 4) begin
        aU = '0;
        startU = 1'b1;
      end
      if (n == 5) startU = 1'b0;
    end
    lastU = exp1;

    applyStimulus(0, t1A, t1B);
    repeat (10) @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    checkOutput("t5 async busy", busyU, 0);
    checkOutput("t5 async done", doneU, 0);
    checkOutput("t5 async resU", resU, 0);
    checkOutput("t5 async resS", resS, 0);
    lastU = '0;
    lastS = '0;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    checkOutput("t5 busy after reset", busyU, 0);
    runOp(0, t2A, t2B, "t5");

    // Start held high: the completion cycle has busy=0, so the next edge restarts.
    exp2 = refMul(t2A, t2B, 0);
    aU = t1A;
    bU = t1B;
    startU = 1'b1;
    @(posedge clk);
    #1;
    for (int n = 1; n <= LAT; n++) begin
      @(posedge clk);
      #1;
      checkOutput("t6 first done", doneU, (n == LAT));
      checkOutput("t6 first result", resU, (n < LAT) ? lastU : exp1);
    end
    aU = t2A;
    bU = t2B;
    @(posedge clk);
    #1;
    checkOutput("t6 restart busy", busyU, 1);
    checkOutput("t6 restart done", doneU, 0);
    for (int n = 1; n <= LAT; n++) begin
      @(posedge clk);
      #1;
      checkOutput("t6 second done", doneU, (n == LAT));
      checkOutput("t6 second result", resU, (n < LAT) ? exp1 : exp2);
    end
    startU = 1'b0;
    @(posedge clk);
    #1;
    checkOutput("t6 idle busy", busyU, 0);
    checkOutput("t6 idle done", doneU, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
